fifo_sync_param: RTL

//  Parametrised single-clock FIFO; next generation of the team's sync FIFO.
//  All DEPTH entries are usable (wrap-bit pointers). Adds occupancy count,

---
 rtl/fifo_sync_param.sv | 97 +++++++++
 1 files changed

// File: rtl/fifo_sync_param.sv
// Single-clock FIFO using wrap-bit pointers, so all DEPTH entries are usable. It has
// an occupancy count, threshold flags and sticky ovf/udf flags. Defining FIFO_SYNC_PARAM_FWFT_EN selects first-word-fall-through.
module fifo_sync_param #(
    parameter int unsigned DATA_WIDTH  = 128,
    parameter int unsigned DEPTH       = 8,
    parameter int unsigned ALMOST_MTY  = 1,
    parameter int unsigned ALMOST_FULL = 1
) (
    input  logic                     clk,
    input  logic                     arst_n,
    input  logic                     wr,
    input  logic [DATA_WIDTH-1:0]    data,
    input  logic                     rd,
    input  logic                     clr_err,
    output logic [DATA_WIDTH-1:0]    q,
    output logic                     full,
    output logic                     almost_full,
    output logic                     mty,
    output logic                     almost_mty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf,
    output logic                     udf
);

    localparam int unsigned AW      = $clog2(DEPTH);
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW:0] AF_TH   = (AW+1)'(DEPTH - ALMOST_FULL);
    localparam logic [AW:0] AM_TH   = (AW+1)'(ALMOST_MTY);
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]           wptr_q, wptr_d;
    logic [AW:0]           rptr_q, rptr_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;
    logic                  wr_ok, rd_ok;

    // Flags are purely combinational from the registered pointers.
    always_comb begin
        count       = wptr_q - rptr_q;
        full        = (count == DEPTH_C);
        mty         = (count == '0);
        almost_full = (count >= AF_TH);
        almost_mty  = (count <= AM_TH);
    end

    always_comb begin
        wr_ok  = wr & (~full | rd);
        rd_ok  = rd & ~mty;
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_ok) wptr_d = wptr_q + PTR_ONE;
        if (rd_ok) rptr_d = rptr_q + PTR_ONE;
        ovf_d  = (wr & full & ~rd) | (ovf_q & ~clr_err);
        udf_d  = (rd & mty) | (udf_q & ~clr_err);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q[AW-1:0]] <= data;
    end

    assign ovf = ovf_q;
    assign udf = udf_q;

`ifdef FIFO_SYNC_PARAM_FWFT_EN
    assign q = mem_q[rptr_q[AW-1:0]];
`else
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

    always_comb begin
        rdata_d = rdata_q;
        if (rd_ok) rdata_d = mem_q[rptr_q[AW-1:0]];
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) rdata_q <= '0;
        else         rdata_q <= rdata_d;
    end

    assign q = rdata_q;
`endif

endmodule
